imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, giving the number of instruction-memory words the loader may write.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the header word count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port trigger, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port byte_in, input, 8 bits: boot stream byte.
REQ-006 SHALL have port byte_valid, input, 1 bit: byte_in is valid this cycle.
REQ-007 SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 SHALL have port restart, input, 1 bit: single-cycle request to reload.
REQ-009 SHALL have port mem_we, output, 1 bit: instruction-memory write strobe.
REQ-010 SHALL have port mem_addr, output, 32 bits: word address, same unit as the core pc.
REQ-011 SHALL have port mem_wdata, output, 32 bits: instruction word.
REQ-012 SHALL have port core_hold, output, 1 bit: holds the core in reset; the core's trigger is ORed with it.
REQ-013 SHALL have port done, output, 1 bit: load completed successfully.
REQ-014 SHALL have port err, output, 1 bit: load failed.
REQ-015 SHALL have port words_loaded, output, CNT_W bits: count of words written.

Function
REQ-016 SHALL treat a byte as accepted only in a cycle where byte_valid and byte_ready are both 1.
REQ-017 SHALL implement states HDR_HI, HDR_LO, DATA, CKSUM, DONE and ERROR.
REQ-018 SHALL drive byte_ready=1 in HDR_HI, HDR_LO, DATA and CKSUM, and 0 in DONE and ERROR.
REQ-019 SHALL take the word count N from the first two accepted bytes, big-endian, with HDR_HI leading to HDR_LO.
REQ-020 SHALL assemble each group of 4 data bytes into one word, first byte into bits [31:24].
REQ-021 SHALL pulse mem_we for exactly 1 cycle, in the cycle after the 4th byte of a word is accepted, with mem_addr equal to the word index (0, 1, ... N-1) and mem_wdata equal to the assembled word.
REQ-022 SHALL keep accepting bytes during that mem_we cycle; the assembly register and the write register are separate, so no byte is lost.
REQ-023 SHALL increment words_loaded with each mem_we pulse.
REQ-024 SHALL leave mem_addr and mem_wdata at their last values while mem_we=0.
REQ-025 SHALL, when N=0, go from HDR_LO directly to the post-data step (CKSUM, or DONE without the checksum feature) with no writes.
REQ-026 SHALL, when N>DEPTH, suppress mem_we for word indexes >= DEPTH, still consume all 4N bytes, leave words_loaded=DEPTH, and end in ERROR.
REQ-027 SHALL, after the last data byte is accepted, enter DONE (or ERROR per REQ-026), or CKSUM when the checksum feature is compiled in.
REQ-028 SHALL register core_hold=0 and done=1 one cycle after the final mem_we pulse, or one cycle after entering DONE when N=0.
REQ-029 SHALL keep core_hold=1 in every state except DONE.
REQ-030 SHALL register err=1 on entry to ERROR, with core_hold=1 and done=0.
REQ-031 SHALL ignore byte_valid in DONE and ERROR.
REQ-032 SHALL, on restart=1 in DONE or ERROR, next cycle enter HDR_HI with core_hold=1, done=0, err=0 and words_loaded=0.
REQ-033 SHALL ignore restart in any other state.

Reset
REQ-034 SHALL, while trigger=1, immediately force state HDR_HI, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, done=0, err=0, words_loaded=0, and clear the assembly byte counter.
REQ-035 SHALL drive byte_ready=1 from the first clk edge after trigger falls.
REQ-036 SHALL, on trigger mid-load, discard the partial word and the header and issue no write for the partial word.

Configuration
REQ-037 SHALL, when IMEM_LOADER_CHECKSUM_EN is defined, expect one extra byte in CKSUM after the data, equal to the XOR of all 4N data bytes; a match goes to DONE per REQ-028, and a mismatch goes to ERROR.
REQ-038 SHALL, when IMEM_LOADER_CHECKSUM_EN is undefined, omit CKSUM and the XOR logic, go straight from the last data byte to DONE, and treat any following byte as ignored per REQ-031.

Verification
REQ-039 SHALL cover: stream 00 02 12 34 56 78 9A BC DE F0 (+ checksum 00 if enabled), byte_valid=1 continuous -> mem_we at addr 0 data 0x12345678 and addr 1 data 0x9ABCDEF0, words_loaded=2, core_hold falls one cycle after the second write.
REQ-040 SHALL cover: header 00 00 (+ checksum 00) -> no mem_we, done=1, core_hold=0.
REQ-041 SHALL cover: DEPTH=4, N=5 -> 4 writes at addr 0-3, 20 data bytes consumed, err=1, core_hold=1.
REQ-042 SHALL cover: trigger pulsed after 3 data bytes, then a fresh N=1 load of AA BB CC DD -> single write 0xAABBCCDD at addr 0.
REQ-043 SHALL cover: checksum enabled, data 01 02 03 04 with checksum 05 -> ERROR, err=1; then restart plus a correct stream with checksum 04 -> done=1.
REQ-044 SHALL cover: byte_valid toggled randomly -> identical writes to the continuous case, and byte_ready=0 throughout DONE.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-stream loader: parses a big-endian word-count header, packs data bytes into
// instruction words, and holds the core in reset until the load completes.
// Optional trailing XOR checksum byte is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             trigger,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             restart,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             core_hold,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CKSUM,
        DONE,
        ERROR
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             armed;
    logic             accept;
    logic [7:0]       hdr_hi_p0;
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] hdr_count;
    logic [CNT_W-1:0] word_idx;
    logic [31:0]      idx_ext;
    logic [1:0]       bcnt_p0;
    logic [23:0]      word_p0;
    logic             word_done;
    logic             last_word;
    logic             in_range;
    logic             ovf;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       cksum_p0;
`endif

    // armed keeps byte_ready low until the first edge after trigger is released
    assign byte_ready = armed && (state inside {HDR_HI, HDR_LO, DATA, CKSUM});
    assign accept     = byte_valid && byte_ready;
    assign hdr_count  = CNT_W'({hdr_hi_p0, byte_in});
    assign idx_ext    = 32'(word_idx);
    assign word_done  = accept && (state == DATA) && (bcnt_p0 == 2'd3);
    assign last_word  = (word_idx == (n_words - CNT_W'(1)));
    assign in_range   = (idx_ext < 32'(DEPTH));
    assign ovf        = (32'(n_words) > 32'(DEPTH));

    always_ff @(posedge clk or posedge trigger) begin
        if (trigger) begin
            state <= HDR_HI;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HDR_HI: begin
                if (accept) begin
                    state_next = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    if (hdr_count != '0) begin
                        state_next = DATA;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = CKSUM;
`else
                        state_next = DONE;
`endif
                    end
                end
            end
            DATA: begin
                if (word_done && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CKSUM;
`else
                    state_next = ovf ? ERROR : DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CKSUM: begin
                if (accept) begin
                    state_next = ((byte_in == cksum_p0) && !ovf) ? DONE : ERROR;
                end
            end
`endif
            DONE, ERROR: begin
                if (restart) begin
                    state_next = HDR_HI;
                end
            end
            default: begin
                state_next = HDR_HI;
            end
        endcase
    end

    // p0: header capture and byte assembly; p1: registered write port and status
    always_ff @(posedge clk or posedge trigger) begin
        if (trigger) begin
            armed        <= 1'b0;
            hdr_hi_p0    <= '0;
            n_words      <= '0;
            word_idx     <= '0;
            bcnt_p0      <= '0;
            word_p0      <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cksum_p0     <= '0;
`endif
        end else begin
            armed     <= 1'b1;
            mem_we    <= 1'b0;
            done      <= (state == DONE) && (state_next == DONE);
            core_hold <= !((state == DONE) && (state_next == DONE));
            err       <= (state_next == ERROR);

            if (accept) begin
                case (state)
                    HDR_HI: begin
                        hdr_hi_p0 <= byte_in;
                    end
                    HDR_LO: begin
                        n_words  <= hdr_count;
                        word_idx <= '0;
                        bcnt_p0  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        cksum_p0 <= '0;
`endif
                    end
                    DATA: begin
                        bcnt_p0 <= bcnt_p0 + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        cksum_p0 <= cksum_p0 ^ byte_in;
`endif
                        if (bcnt_p0 == 2'd3) begin
                            word_idx <= word_idx + CNT_W'(1);
                            // words past the end of memory are consumed but never written
                            if (in_range) begin
                                mem_we       <= 1'b1;
                                mem_addr     <= idx_ext;
                                mem_wdata    <= {word_p0, byte_in};
                                words_loaded <= words_loaded + CNT_W'(1);
                            end
                        end else begin
                            word_p0 <= {word_p0[15:0], byte_in};
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (((state == DONE) || (state == ERROR)) && restart) begin
                words_loaded <= '0;
                word_idx     <= '0;
                bcnt_p0      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads, hand-written reset/checksum
// sequences and randomized loads checked against a stream-level reference model.
module tb_imem_loader;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    typedef struct {
        int          n;
        logic [31:0] base;
        logic [31:0] step;
        bit          rnd_data;
        bit          rnd_valid;
        int          exp_wl;
        bit          exp_err;
    } vec_t;

    logic             clk;
    logic             trigger;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             restart;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             core_hold;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_we = -1;
    int fall = -1;
    int err_rise = -1;
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .trigger(trigger),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .restart(restart),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .core_hold(core_hold),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cycle counter and write/status monitor, sampled 1 time unit after each edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (mem_we === 1'b1) begin
                got_a.push_back(mem_addr);
                got_d.push_back(mem_wdata);
                last_we = cyc;
            end
            if (core_hold === 1'b0 && fall < 0) fall = cyc;
            if (err === 1'b1 && err_rise < 0) err_rise = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_core_hold"}, 64'(core_hold), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    task automatic drive_bytes(input byte_q_t bytes, input bit rnd_valid,
                               output int consumed, output int last_acc);
        int spent;
        bit acc;
        consumed = 0;
        last_acc = -1;
        spent = 0;
        while (consumed < bytes.size() && spent < 600) begin
            @(negedge clk);
            byte_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_in = bytes[consumed];
            acc = byte_valid && byte_ready;
            if (acc) last_acc = cyc + 1;
            @(posedge clk);
            if (acc) consumed++;
            spent++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic drive_and_check(input string tag, input byte_q_t bytes, input word_q_t exp_a,
                                   input word_q_t exp_d, input bit rnd_valid,
                                   input int exp_wl, input bit exp_err);
        int consumed;
        int last_acc;
        int nchk;
        got_a.delete();
        got_d.delete();
        fall = -1;
        err_rise = -1;
        last_we = -1;
        drive_bytes(bytes, rnd_valid, consumed, last_acc);
        chk({tag, "_consumed"}, 64'(consumed), 64'(bytes.size()));
        repeat (3) @(negedge clk);
        chk({tag, "_nwrites"}, 64'(got_a.size()), 64'(exp_a.size()));
        nchk = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < nchk; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(got_a[i]), 64'(exp_a[i]));
            chk($sformatf("%s_data%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
        end
        chk({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_wl));
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        chk({tag, "_done"}, 64'(done), 64'(!exp_err));
        chk({tag, "_core_hold"}, 64'(core_hold), 64'(exp_err));
        if (exp_err) begin
            chk({tag, "_err_timing"}, 64'(err_rise), 64'(last_acc));
        end else begin
            chk({tag, "_hold_timing"}, 64'(fall), 64'(last_acc + 1));
            if (!rnd_valid && exp_a.size() > 0)
                chk({tag, "_hold_after_we"}, 64'(fall), 64'(last_we + 1 + int'(CK)));
        end
        // bytes offered after the load must be refused
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_in = 8'h5A;
            chk($sformatf("%s_ready_idle%0d", tag, i), 64'(byte_ready), 64'd0);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_no_extra_write"}, 64'(got_a.size()), 64'(exp_a.size()));
        chk({tag, "_done_held"}, 64'(done), 64'(!exp_err));
    endtask

    // reference model: build the boot stream and the expected write list from the word list
    task automatic run_load(input string tag, input int n, input word_q_t words,
                            input bit rnd_valid, input int exp_wl, input bit exp_err);
        byte_q_t bytes;
        word_q_t exp_a;
        word_q_t exp_d;
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'h00;
        bytes.push_back(8'((n >> 8) & 255));
        bytes.push_back(8'(n & 255));
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int b = 3; b >= 0; b--) begin
                bytes.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
            if (i < DEPTH) begin
                exp_a.push_back(32'(i));
                exp_d.push_back(w);
            end
        end
        if (CK) bytes.push_back(x);
        drive_and_check(tag, bytes, exp_a, exp_d, rnd_valid, exp_wl, exp_err);
    endtask

    task automatic do_restart(input string tag);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk({tag, "_core_hold"}, 64'(core_hold), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
        chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd1);
    endtask

    initial begin
        vec_t    vecs[6];
        word_q_t words;
        byte_q_t bq;
        word_q_t ea;
        word_q_t ed;
        int      n;
        int      consumed;
        int      last_acc;

        vecs[0] = '{2, 32'h12345678, 32'h88888878, 1'b0, 1'b0, 2, 1'b0};
        vecs[1] = '{0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0};
        vecs[2] = '{5, 32'hA0B0C0D0, 32'h01010101, 1'b0, 1'b0, 4, 1'b1};
        vecs[3] = '{2, 32'h12345678, 32'h88888878, 1'b0, 1'b1, 2, 1'b0};
        vecs[4] = '{4, 32'h0, 32'h0, 1'b1, 1'b0, 4, 1'b0};
        vecs[5] = '{1, 32'h0, 32'h0, 1'b1, 1'b1, 1, 1'b0};

        trigger = 1'b1;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        restart = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        trigger = 1'b0;
        #1;
        chk("rst_ready_before_edge", 64'(byte_ready), 64'd0);
        @(posedge clk);
        #2;
        chk("rst_ready_after_edge", 64'(byte_ready), 64'd1);
        chk("rst_hold_after_edge", 64'(core_hold), 64'd1);

        for (int v = 0; v < 6; v++) begin
            if (v != 0) do_restart($sformatf("restart_v%0d", v));
            words.delete();
            for (int i = 0; i < vecs[v].n; i++)
                words.push_back(vecs[v].rnd_data ? $urandom() : vecs[v].base + 32'(i) * vecs[v].step);
            run_load($sformatf("vec%0d", v), vecs[v].n, words, vecs[v].rnd_valid,
                     vecs[v].exp_wl, vecs[v].exp_err);
        end

        // trigger in the middle of a word: partial word and header are dropped
        do_restart("restart_mid");
        got_a.delete();
        got_d.delete();
        bq = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        drive_bytes(bq, 1'b0, consumed, last_acc);
        chk("mid_consumed", 64'(consumed), 64'd5);
        #2;
        trigger = 1'b1;
        #1;
        chk_reset_outputs("mid_async");
        @(negedge clk);
        trigger = 1'b0;
        #1;
        chk("mid_ready_before_edge", 64'(byte_ready), 64'd0);
        chk("mid_no_partial_write", 64'(got_a.size()), 64'd0);
        words = '{32'hAABBCCDD};
        run_load("mid_reload", 1, words, 1'b0, 1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_restart("ck_restart0");
        bq = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        ea = '{32'd0};
        ed = '{32'h01020304};
        drive_and_check("ck_bad", bq, ea, ed, 1'b0, 1, 1'b1);
        do_restart("ck_restart1");
        bq[6] = 8'h04;
        drive_and_check("ck_good", bq, ea, ed, 1'b0, 1, 1'b0);
`else
        ea.delete();
        ed.delete();
`endif

        for (int r = 0; r < 6; r++) begin
            do_restart($sformatf("restart_r%0d", r));
            n = $urandom_range(0, 6);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom());
            run_load($sformatf("rnd%0d_n%0d", r, n), n, words, 1'b1,
                     (n < DEPTH) ? n : DEPTH, n > DEPTH);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
